mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  host command valid.
REQ-006 SHALL have port req_ready  output  1  command accepted when req_valid && req_ready at clk edge.
REQ-007 SHALL have port req_we  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port req_addr  input  ADDR_W  burst start address.
REQ-009 SHALL have port req_len  input  2  beats minus one (0..3 = 1..4 beats).
REQ-010 SHALL have port wd_valid / wd_ready / wd_data  input / output / input  1 / 1 / DATA_W  write-data beat handshake.
REQ-011 SHALL have port rd_valid / rd_ready / rd_data / rd_last  output / input / output / output  1 / 1 / DATA_W / 1  read-data beat handshake; rd_last marks final beat.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port mem_addr / mem_we / mem_wdata  output  ADDR_W / 1 / DATA_W  drive to memory port.
REQ-014 SHALL have port mem_rdata  input  DATA_W  memory registered read data, valid one cycle after mem_addr presented with mem_we=0.

Function
REQ-015 SHALL implement states IDLE, WR, RD_ADDR, RD_DATA.
REQ-016 IDLE: req_ready=1; on accept latch addr counter=req_addr, beat counter=req_len; go WR if req_we else RD_ADDR.
REQ-017 WR: wd_ready=1; mem_we = wd_valid (combinational); mem_wdata=wd_data; mem_addr=addr counter.
REQ-018 WR: on wd_valid, addr counter +1; if beat counter==0 go IDLE, else beat counter -1 and stay.
REQ-019 WR with wd_valid=0: mem_we=0, no counter change, stall indefinitely.
REQ-020 RD_ADDR: mem_we=0, mem_addr=addr counter; unconditionally go RD_DATA next cycle.
REQ-021 RD_DATA entry: capture mem_rdata into rd_data register on the RD_ADDR->RD_DATA edge; rd_valid=1; rd_last=(beat counter==0).
REQ-022 RD_DATA: rd_data, rd_last stable while rd_valid && !rd_ready.
REQ-023 RD_DATA on rd_ready: addr counter +1; if beat counter==0 go IDLE, else beat counter -1, go RD_ADDR.
REQ-024 Read beat throughput SHALL be one beat per 2 cycles max; write beat one per cycle max.
REQ-025 Address counter SHALL wrap modulo 2^ADDR_W (3 -> 0) within a burst.
REQ-026 mem_we SHALL be 0 in every state except WR with wd_valid=1.
REQ-027 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE ignored, not queued.
REQ-028 wd_ready SHALL be 0 outside WR; rd_valid SHALL be 0 outside RD_DATA.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 rst low SHALL immediately (no clk) force state IDLE, counters 0, rd_data 0, rd_valid 0, rd_last 0, wd_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0.
REQ-031 req_ready SHALL be 0 while rst low, 1 from first cycle after rst high.
REQ-032 rst low mid-burst SHALL abort burst; no further mem_we pulse; outstanding read beat discarded.

Verification
REQ-033 Write burst: req addr=1 len=2 we=1, wd_data A1,B2,C3 back-to-back -> mem_we high 3 cycles at mem_addr 1,2,3; then req_ready=1.
REQ-034 Read wrap: memory preloaded [0]=10,[3]=40; req addr=3 len=1 we=0, rd_ready=1 -> rd_data 40 (rd_last 0) then 10 (rd_last 1), mem_addr 3 then 0.
REQ-035 Backpressure: read len=0, rd_ready=0 for 5 cycles -> rd_valid and rd_data held constant 5 cycles, mem_we stays 0, completes on rd_ready=1.
REQ-036 Write stall: wd_valid toggled 1,0,0,1 on len=1 -> exactly 2 mem_we pulses, addr advances only on those.
REQ-037 Reset mid-read: assert rst while in RD_DATA -> rd_valid 0 and busy 0 same cycle without clk edge; after release, new write to addr 0 accepted normally.
REQ-038 Request while busy: req_valid held during write burst -> req_ready 0 until IDLE; second request accepted on first IDLE cycle.

Source files
------------

// File: rtl/mem_master_if.sv
// Host command, write-data, read-data and memory-port signals of mem_master.
// master is the controller's view; slave is the host/memory side.
interface mem_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_len;

  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rd_ready, mem_rdata,
    output req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rd_ready, mem_rdata,
    input  req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_master.sv
// Burst memory controller: 1..4-beat writes at one beat/cycle, reads at one beat per 2 cycles.
// Write beats stall on wd_valid; read beats hold rd_data/rd_last until rd_ready; new commands only in IDLE.
module mem_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input logic        clk,
  input logic        rst,
  mem_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_nxt;
  logic [1:0]        beat_cnt, beat_nxt;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_last_q;
  logic              cap_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      beat_cnt  <= '0;
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_cnt <= addr_nxt;
      beat_cnt <= beat_nxt;
      // Memory data for the current address has settled by the end of RD_ADDR.
      if (cap_rd) begin
        rd_data_q <= bus.mem_rdata;
        rd_last_q <= (beat_cnt == 2'd0);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_cnt;
    beat_nxt      = beat_cnt;
    cap_rd        = 1'b0;
    bus.req_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.rd_valid  = 1'b0;

    case (state)
      IDLE: begin
        // Gated by rst so no command appears accepted while reset is held.
        bus.req_ready = rst;
        if (bus.req_valid) begin
          addr_nxt  = bus.req_addr;
          beat_nxt  = bus.req_len;
          state_nxt = bus.req_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        bus.wd_ready  = 1'b1;
        bus.mem_we    = bus.wd_valid;
        bus.mem_wdata = bus.wd_data;
        if (bus.wd_valid) begin
          addr_nxt = addr_cnt + ADDR_W'(1);
          if (beat_cnt == 2'd0) state_nxt = IDLE;
          else                  beat_nxt  = beat_cnt - 2'd1;
        end
      end
      RD_ADDR: begin
        cap_rd    = 1'b1;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_ready) begin
          addr_nxt = addr_cnt + ADDR_W'(1);
          if (beat_cnt == 2'd0) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt  = beat_cnt - 2'd1;
            state_nxt = RD_ADDR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_addr = addr_cnt;
  assign bus.busy     = (state != IDLE);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = rd_last_q;

endmodule

// File: tb/tb_mem_master.sv
// Table-driven cycle vectors for mem_master plus hand-written reset and memory-content sequences.
// Each row is driven at the falling edge and the outputs compared 1 time unit later.
module tb_mem_master;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: write on the clock edge, read data settles within the address cycle.
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (!rst) begin
      mem[0] <= 8'h10;
      mem[1] <= 8'h00;
      mem[2] <= 8'h00;
      mem[3] <= 8'h40;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct packed {
    logic       rv;
    logic       we;
    logic [1:0] addr;
    logic [1:0] len;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
  } stim_t;

  typedef struct packed {
    logic       busy;
    logic       rq_rdy;
    logic       wd_rdy;
    logic       mwe;
    logic [1:0] maddr;
    logic [7:0] mwdata;
    logic       rvld;
    logic [7:0] rdata;
    logic       rlast;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic stim_t st(int rv, int we, int a, int l, int wv, int wd, int rr);
    stim_t r;
    r.rv = 1'(rv); r.we = 1'(we); r.addr = 2'(a); r.len = 2'(l);
    r.wv = 1'(wv); r.wd = 8'(wd); r.rr = 1'(rr);
    return r;
  endfunction

  function automatic exp_t ex(int bsy, int rq, int wdr, int mwe, int ma, int mwd,
                              int rv, int rd, int rl);
    exp_t r;
    r.busy = 1'(bsy); r.rq_rdy = 1'(rq); r.wd_rdy = 1'(wdr); r.mwe = 1'(mwe);
    r.maddr = 2'(ma); r.mwdata = 8'(mwd); r.rvld = 1'(rv); r.rdata = 8'(rd); r.rlast = 1'(rl);
    return r;
  endfunction

  task automatic add(string n, stim_t s, exp_t e);
    vec_t v;
    v.name = n; v.s = s; v.e = e;
    vq.push_back(v);
  endtask

  task automatic drive(stim_t s);
    bus.req_valid = s.rv;
    bus.req_we    = s.we;
    bus.req_addr  = s.addr;
    bus.req_len   = s.len;
    bus.wd_valid  = s.wv;
    bus.wd_data   = s.wd;
    bus.rd_ready  = s.rr;
  endtask

  function automatic exp_t observe();
    exp_t r;
    r.busy = bus.busy; r.rq_rdy = bus.req_ready; r.wd_rdy = bus.wd_ready;
    r.mwe = bus.mem_we; r.maddr = bus.mem_addr; r.mwdata = bus.mem_wdata;
    r.rvld = bus.rd_valid; r.rdata = bus.rd_data; r.rlast = bus.rd_last;
    return r;
  endfunction

  task automatic check_vec(string n, exp_t act, exp_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b rq_rdy=%b wd_rdy=%b mwe=%b maddr=%0d mwdata=%h rvld=%b rdata=%h rlast=%b, expected busy=%b rq_rdy=%b wd_rdy=%b mwe=%b maddr=%0d mwdata=%h rvld=%b rdata=%h rlast=%b",
               n, act.busy, act.rq_rdy, act.wd_rdy, act.mwe, act.maddr, act.mwdata, act.rvld, act.rdata, act.rlast,
               exp.busy, exp.rq_rdy, exp.wd_rdy, exp.mwe, exp.maddr, exp.mwdata, exp.rvld, exp.rdata, exp.rlast);
    end
  endtask

  task automatic check_val(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t obs;

    // Read wrap: addr 3, two beats, memory [3]=40 then [0]=10.
    add("rw_acc",  st(1,0,3,1,0,0,1), ex(0,1,0,0,0,0,0,0,0));
    add("rw_a0",   st(0,0,0,0,0,0,1), ex(1,0,0,0,3,0,0,0,0));
    add("rw_d0",   st(0,0,0,0,0,0,1), ex(1,0,0,0,3,0,1,'h40,0));
    add("rw_a1",   st(0,0,0,0,0,0,1), ex(1,0,0,0,0,0,0,0,0));
    add("rw_d1",   st(0,0,0,0,0,0,1), ex(1,0,0,0,0,0,1,'h10,1));
    // Write burst: addr 1, three back-to-back beats.
    add("wb_acc",  st(1,1,1,2,0,0,0), ex(0,1,0,0,1,0,0,0,0));
    add("wb_0",    st(0,0,0,0,1,'hA1,0), ex(1,0,1,1,1,'hA1,0,0,0));
    add("wb_1",    st(0,0,0,0,1,'hB2,0), ex(1,0,1,1,2,'hB2,0,0,0));
    add("wb_2",    st(0,0,0,0,1,'hC3,0), ex(1,0,1,1,3,'hC3,0,0,0));
    // Read backpressure: single beat from addr 2, held for five cycles.
    add("bp_acc",  st(1,0,2,0,0,0,0), ex(0,1,0,0,0,0,0,0,0));
    add("bp_a",    st(0,0,0,0,0,0,0), ex(1,0,0,0,2,0,0,0,0));
    for (int i = 0; i < 5; i++)
      add($sformatf("bp_hold%0d", i), st(0,0,0,0,0,0,0), ex(1,0,0,0,2,0,1,'hB2,1));
    add("bp_done", st(0,0,0,0,0,0,1), ex(1,0,0,0,2,0,1,'hB2,1));
    // Write stall: wd_valid 1,0,0,1 on a two-beat burst to addr 0.
    add("st_acc",  st(1,1,0,1,0,0,0), ex(0,1,0,0,3,0,0,0,0));
    add("st_w0",   st(0,0,0,0,1,'h5A,0), ex(1,0,1,1,0,'h5A,0,0,0));
    add("st_s0",   st(0,0,0,0,0,0,0), ex(1,0,1,0,1,0,0,0,0));
    add("st_s1",   st(0,0,0,0,0,0,0), ex(1,0,1,0,1,0,0,0,0));
    add("st_w1",   st(0,0,0,0,1,'h6B,0), ex(1,0,1,1,1,'h6B,0,0,0));
    // Request held during a write burst; taken on the first IDLE cycle.
    add("bz_acc",  st(1,1,2,1,0,0,0), ex(0,1,0,0,2,0,0,0,0));
    add("bz_w0",   st(1,0,0,0,1,'h77,0), ex(1,0,1,1,2,'h77,0,0,0));
    add("bz_w1",   st(1,0,0,0,1,'h88,0), ex(1,0,1,1,3,'h88,0,0,0));
    add("bz_acc2", st(1,0,0,0,0,0,0), ex(0,1,0,0,0,0,0,0,0));
    add("bz_ra",   st(0,0,0,0,0,0,1), ex(1,0,0,0,0,0,0,0,0));
    add("bz_rd",   st(0,0,0,0,0,0,1), ex(1,0,0,0,0,0,1,'h5A,1));
    add("idle",    st(0,0,0,0,0,0,0), ex(0,1,0,0,1,0,0,0,0));

    // Reset state, with nonzero write data to show mem_wdata is forced low.
    drive(st(1,1,2,3,1,'hFF,1));
    #1;
    check_vec("reset_outs", observe(), ex(0,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    check_vec("reset_hold", observe(), ex(0,0,0,0,0,0,0,0,0));
    drive(st(0,0,0,0,0,0,0));
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].s);
      #1;
      obs = observe();
      if (!vq[i].e.rvld) begin
        obs.rdata = 8'h00;
        obs.rlast = 1'b0;
      end
      check_vec(vq[i].name, obs, vq[i].e);
    end

    check_val("mem0", 32'(mem[0]), 32'h5A);
    check_val("mem1", 32'(mem[1]), 32'h6B);
    check_val("mem2", 32'(mem[2]), 32'h77);
    check_val("mem3", 32'(mem[3]), 32'h88);

    // Reset asserted while a read beat is waiting for rd_ready.
    @(negedge clk);
    drive(st(1,0,3,1,0,0,0));
    @(negedge clk);
    drive(st(0,0,0,0,0,0,0));
    @(negedge clk);
    #1;
    check_val("mr_pre_rvld", 32'(bus.rd_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_vec("mr_async", observe(), ex(0,0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    check_vec("mr_held", observe(), ex(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    drive(st(1,1,0,0,0,0,0));
    #1;
    check_vec("rel_acc", observe(), ex(0,1,0,0,0,0,0,0,0));
    @(negedge clk);
    drive(st(0,0,0,0,1,'h99,0));
    #1;
    check_vec("rel_w", observe(), ex(1,0,1,1,0,'h99,0,0,0));
    @(negedge clk);
    drive(st(0,0,0,0,0,0,0));
    #1;
    check_vec("rel_idle", observe(), ex(0,1,0,0,1,0,0,0,0));
    check_val("rel_mem0", 32'(mem[0]), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
